pc_call_stack: RTL
==================

PC_CALL_STACK -- requirements
Module: pc_call_stack

Interface
REQ-001 Parameter WIDTH, default 4: program counter and bus width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries; legal range 1..16.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: when 1, out drives pc; when 0, out is high-impedance.
REQ-006 Port inc, input, 1: advance pc by 1.
REQ-007 Port ld, input, 1: absolute jump, pc <= bus_in.
REQ-008 Port br, input, 1: relative branch, pc <= pc + bus_in.
REQ-009 Port call, input, 1: push return address, then jump to bus_in.
REQ-010 Port ret, input, 1: pop return address into pc.
REQ-011 Port bus_in, input, WIDTH: jump target or branch offset.
REQ-012 Port out, output tri, WIDTH: tristated pc onto the shared bus.
REQ-013 Port pc, output, WIDTH: current pc, always driven.
REQ-014 Port stk_empty, output, 1: stack holds 0 entries.
REQ-015 Port stk_full, output, 1: stack holds DEPTH entries.
REQ-016 Port err, output, 1: sticky overflow/underflow flag.

Function
REQ-017 Command priority SHALL be ld > call > ret > br > inc; the block executes only the highest asserted command each cycle, and none means hold.
REQ-018 inc: pc <= (pc + 1) mod 2^WIDTH; all-ones wraps to 0.
REQ-019 br: pc <= (pc + bus_in) mod 2^WIDTH; bus_in is two's complement, so all-ones means -1.
REQ-020 call, not full: stack[sp] <= (pc + 1) mod 2^WIDTH; sp <= sp + 1; pc <= bus_in; all in the same edge.
REQ-021 call while stk_full: no push, pc unchanged, err <= 1.
REQ-022 ret, not empty: pc <= stack[sp - 1]; sp <= sp - 1.
REQ-023 ret while stk_empty: pc unchanged, sp unchanged, err <= 1.
REQ-024 Stack is LIFO; sp width is ceil(log2(DEPTH + 1)); sp never exceeds DEPTH and never goes below 0.
REQ-025 stk_empty = (sp == 0) and stk_full = (sp == DEPTH), both decoded combinationally from registered sp.
REQ-026 Latency: every command takes effect on pc/sp at the first rising edge after it is sampled, with no pipeline bubbles; back-to-back commands on consecutive cycles are legal.
REQ-027 out and pc reflect registered pc only; en is combinational to out, with no clock dependency.
REQ-028 err, once set, holds until rst; subsequent legal commands execute normally while err=1.
REQ-029 ld or br asserted together with call/ret: only the winner per REQ-017 acts, and a masked call/ret causes no stack change and no err.

Reset
REQ-030 On rst=1 at a clock edge: pc <= 0, sp <= 0, err <= 0; stk_empty=1, stk_full=0 after that edge.
REQ-031 Stack entry contents are not reset; they are unobservable until written.
REQ-032 rst overrides all commands in the same cycle, including a reset arriving mid call/ret sequence.
REQ-033 With en=0 during reset, out stays high-impedance.

Verification
REQ-034 WIDTH=4: rst, then 16 inc cycles -> pc counts 1..15 then 0; en=0 -> out=zzzz; en=1 -> out=pc.
REQ-035 pc=5, br with bus_in=4'b1110 -> pc=3; then br with bus_in=4'b0011 -> pc=6; ld with bus_in=9 -> pc=9.
REQ-036 DEPTH=4: pc=2; call 8, call 12, ret, ret -> pc sequence 8, 12, 9, 3; stk_empty=1 at end; err=0.
REQ-037 DEPTH=4: 4 calls -> stk_full=1; 5th call -> pc unchanged, err=1; 4 rets return correct addresses; 5th ret -> err stays 1, pc unchanged.
REQ-038 Priority: ld=call=inc=1, bus_in=7 -> pc=7, sp unchanged; call=ret=1 at sp=0 -> push occurs, no err.
REQ-039 Two calls issued, then rst asserted together with ret -> pc=0, sp=0, err=0; a following ret sets err=1.

Source files
------------

// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with inc/jump/branch and a LIFO return-address stack
module pc_call_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             ld,
    input  logic             br,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] bus_in,
    output tri   [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pc,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             err
);

    // sp counts 0..DEPTH inclusive; the stack index only needs to address 0..DEPTH-1
    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic             push_en;
    logic [WIDTH-1:0] pc_plus1;
    logic [IDXW-1:0]  push_idx;
    logic [IDXW-1:0]  pop_idx;

    // Entries are deliberately not reset; a slot is only read after it was pushed
    logic [WIDTH-1:0] stack_q [DEPTH];

    assign pc_plus1  = pc_q + 1'b1;
    assign push_idx  = IDXW'(sp_q);
    assign pop_idx   = IDXW'(sp_q - 1'b1);
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SPW'(DEPTH));
    assign pc        = pc_q;
    assign err       = err_q;

    // The bus is released whenever en is low, independent of the clock
    assign out = en ? pc_q : {WIDTH{1'bz}};

    // Next-state decode: only the highest-priority command acts (ld > call > ret > br > inc)
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (ld) begin
            pc_d = bus_in;
        end else if (call) begin
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + 1'b1;
                pc_d    = bus_in;
            end
        end else if (ret) begin
            if (stk_empty) begin
                err_d = 1'b1;
            end else begin
                sp_d = sp_q - 1'b1;
                pc_d = stack_q[pop_idx];
            end
        end else if (br) begin
            pc_d = pc_q + bus_in;
        end else if (inc) begin
            pc_d = pc_plus1;
        end
    end

    // Control state: reset wins over any command in the same cycle; err is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage: push writes pc+1 into the slot at sp
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack_q[push_idx] <= pc_plus1;
        end
    end

endmodule
